// File: rtl/fifo_ext.sv
// Synchronous FIFO with registered or first-word-fall-through reads,
// occupancy count, almost-full/empty levels and sticky error flags.
module fifo_ext #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_WrEn,
  input  logic [WIDTH-1:0]           i_WrData,
  input  logic                       i_RdEn,
  input  logic                       i_ClrFlags,
  output logic [WIDTH-1:0]           o_RdData,
  output logic                       o_RdValid,
  output logic                       o_Full,
  output logic                       o_Empty,
  output logic                       o_AlmostFull,
  output logic                       o_AlmostEmpty,
  output logic [$clog2(DEPTH):0]     o_Count,
  output logic                       o_OverFlow,
  output logic                       o_UnderFlow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AE_C   = CW'(AEMPTY_LVL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             rd_ok;
  logic             wr_ok;
  logic             ovf;
  logic             udf;

  // Status decodes straight off the registered count.
  assign o_Empty       = (count == '0);
  assign o_Full        = (count == FULL_C);
  assign o_AlmostFull  = (count >= AF_C);
  assign o_AlmostEmpty = (count <= AE_C);
  assign o_Count       = count;
  assign o_OverFlow    = ovf;
  assign o_UnderFlow   = udf;

  // A full FIFO still takes a write if the head is popped this cycle.
  assign rd_ok = i_RdEn && !o_Empty;
  assign wr_ok = i_WrEn && (!o_Full || rd_ok);

  // Storage is not reset; writes are blocked while reset is held.
  always_ff @(posedge i_Clk) begin
    if (wr_ok && !i_Rst) begin
      mem[wr_ptr] <= i_WrData;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy moves only when exactly one side is accepted.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count <= '0;
    end else begin
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky errors; a new error wins over a clear in the same cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (ovf && !i_ClrFlags) || (i_WrEn && !wr_ok);
      udf <= (udf && !i_ClrFlags) || (i_RdEn && !rd_ok);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always visible while the FIFO holds data.
      assign o_RdData  = mem[rd_ptr];
      assign o_RdValid = !o_Empty;
    end else begin : g_reg
      logic [WIDTH-1:0] rd_q;
      logic             vld_q;

      // Registered read: data one cycle after the pop, valid pulses.
      always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
          rd_q  <= '0;
          vld_q <= 1'b0;
        end else begin
          vld_q <= rd_ok;
          if (rd_ok) rd_q <= mem[rd_ptr];
        end
      end

      assign o_RdData  = rd_q;
      assign o_RdValid = vld_q;
    end
  endgenerate

endmodule
